// File: rtl/cpu_run_pkg.sv
// Shared definitions for the CPU run/step controller.
package cpu_run_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_BOOT      = 3'd1,
        ST_RUN       = 3'd2,
        ST_STEP_WAIT = 3'd3,
        ST_HALTED    = 3'd4
    } state_t;

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchronizer followed by a level debouncer: the output level
// changes only after DEBOUNCE_CYCLES consecutive disagreeing samples.
module input_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // Any agreeing sample restarts the run of disagreeing samples.
            if (sync2 != level) begin
                if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    level <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step controller for the single-cycle CPU: boots it through a held
// reset, gates it with a clock enable, detects self-loops and counts cycles.
module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned RESET_HOLD      = 4,
    parameter int unsigned CNT_W           = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sw_run,
    input  logic               sw_step_mode,
    input  logic               btn_step,
    input  logic [31:0]        pc_value,
    output logic               cpu_start,
    output logic               cpu_ce,
    output logic               halted,
    output logic [STATE_W-1:0] state_o,
    output logic [CNT_W-1:0]   cycle_count
);

    localparam int unsigned HOLD_W = $clog2(RESET_HOLD + 1);

    logic              run_lvl;
    logic              step_mode_lvl;
    logic              step_lvl;
    logic              step_lvl_q;
    logic              step_pulse;
    logic              halt_hit;
    logic              prev_valid;
    logic [31:0]       prev_pc;
    logic [HOLD_W-1:0] boot_cnt;
    state_t            state;
    state_t            state_next;

    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
        .clk(clk), .rst(rst), .raw(sw_run), .level(run_lvl)
    );
    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk(clk), .rst(rst), .raw(sw_step_mode), .level(step_mode_lvl)
    );
    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
        .clk(clk), .rst(rst), .raw(btn_step), .level(step_lvl)
    );

    assign state_o = state;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Outputs decode the state register; next state with run=0 taking priority.
    always_comb begin
        state_next = state;
        cpu_start  = 1'b0;
        cpu_ce     = 1'b0;
        halt_hit   = 1'b0;
        case (state)
            ST_BOOT:      cpu_ce = 1'b1;
            ST_RUN:       begin cpu_start = 1'b1; cpu_ce = 1'b1;       end
            ST_STEP_WAIT: begin cpu_start = 1'b1; cpu_ce = step_pulse; end
            ST_HALTED:    cpu_start = 1'b1;
            default:      ;
        endcase
        halt_hit = cpu_ce && prev_valid && (pc_value == prev_pc);
        if (!run_lvl) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: state_next = ST_BOOT;
                ST_BOOT:
                    if (boot_cnt == HOLD_W'(RESET_HOLD - 1))
                        state_next = step_mode_lvl ? ST_STEP_WAIT : ST_RUN;
                ST_RUN:
                    if (halt_hit)           state_next = ST_HALTED;
                    else if (step_mode_lvl) state_next = ST_STEP_WAIT;
                ST_STEP_WAIT:
                    if (halt_hit)            state_next = ST_HALTED;
                    else if (!step_mode_lvl) state_next = ST_RUN;
                ST_HALTED: state_next = ST_HALTED;
                default:   state_next = ST_IDLE;
            endcase
        end
    end

    // Step edge detect, boot hold timer, halt detector and cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_lvl_q  <= 1'b0;
            step_pulse  <= 1'b0;
            boot_cnt    <= '0;
            prev_pc     <= '0;
            prev_valid  <= 1'b0;
            cycle_count <= '0;
            halted      <= 1'b0;
        end else begin
            step_lvl_q <= step_lvl;
            step_pulse <= step_lvl & ~step_lvl_q;
            boot_cnt   <= (state == ST_BOOT) ? boot_cnt + HOLD_W'(1) : '0;

            if (state == ST_BOOT) begin
                cycle_count <= '0;
                prev_valid  <= 1'b0;
            end else if (cpu_ce && (state == ST_RUN || state == ST_STEP_WAIT)) begin
                prev_pc    <= pc_value;
                prev_valid <= 1'b1;
                if (cycle_count != '1) cycle_count <= cycle_count + CNT_W'(1);
            end

            // Sticky until the next boot so the display survives a run-off.
            if (state_next == ST_BOOT)        halted <= 1'b0;
            else if (state_next == ST_HALTED) halted <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed plus randomized checks of cpu_run_ctrl against expectations
// derived from its run/step/halt rules.
module tb_cpu_run_ctrl;
    import cpu_run_pkg::*;

    logic        clk = 1'b0;
    logic        rst, sw_run, sw_step_mode, btn_step;
    logic [31:0] pc_value;
    logic        cpu_start, cpu_ce, halted;
    logic [2:0]  state_o;
    logic [31:0] cycle_count;
    logic        sat_start, sat_ce, sat_halted;
    logic [2:0]  sat_state;
    logic [3:0]  sat_count;

    int unsigned nvec = 0;
    int unsigned nerr = 0;

    cpu_run_ctrl #(.DEBOUNCE_CYCLES(4), .RESET_HOLD(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .sw_run(sw_run), .sw_step_mode(sw_step_mode),
        .btn_step(btn_step), .pc_value(pc_value), .cpu_start(cpu_start),
        .cpu_ce(cpu_ce), .halted(halted), .state_o(state_o), .cycle_count(cycle_count)
    );

    cpu_run_ctrl #(.DEBOUNCE_CYCLES(4), .RESET_HOLD(4), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .sw_run(sw_run), .sw_step_mode(sw_step_mode),
        .btn_step(btn_step), .pc_value(pc_value), .cpu_start(sat_start),
        .cpu_ce(sat_ce), .halted(sat_halted), .state_o(sat_state), .cycle_count(sat_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input state_t s, input string tag);
        int n = 0;
        while (state_o !== 3'(s) && n < 30) begin
            tick();
            n++;
        end
        chk(tag, 32'(state_o), 32'(s));
    endtask

    function automatic logic [31:0] sat15(input int unsigned v);
        return (v > 15) ? 32'd15 : 32'(v);
    endfunction

    initial begin
        int unsigned cnt_m;
        int unsigned ce_cycles;
        int unsigned ce_rises;
        logic        prev_ce;
        logic        hit;
        logic [31:0] q[$];

        rst = 1'b1; sw_run = 1'b0; sw_step_mode = 1'b0; btn_step = 1'b0; pc_value = '0;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_state", 32'(state_o), 32'(ST_IDLE));
        chk("rst_start", 32'(cpu_start), 0);
        chk("rst_ce", 32'(cpu_ce), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_count", cycle_count, 0);

        // Boot latency: 2 sync + 4 debounce + 1 FSM edge
        sw_run = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("boot_latency_idle", 32'(state_o), 32'(ST_IDLE));
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("boot_state", 32'(state_o), 32'(ST_BOOT));
            chk("boot_start", 32'(cpu_start), 0);
            chk("boot_ce", 32'(cpu_ce), 1);
            pc_value += 32'd4;
            tick();
        end

        // Free run, 20 enabled cycles; the 4-bit instance must saturate
        for (int unsigned i = 0; i < 20; i++) begin
            chk("run_state", 32'(state_o), 32'(ST_RUN));
            chk("run_start", 32'(cpu_start), 1);
            chk("run_count", cycle_count, 32'(i));
            chk("sat_count", 32'(sat_count), sat15(i));
            pc_value += 32'd4;
            tick();
        end
        chk("run_count20", cycle_count, 32'd20);
        chk("sat_hold15", 32'(sat_count), 32'd15);

        // Run switch off: 6 more RUN cycles, then IDLE
        sw_run = 1'b0;
        for (int i = 0; i < 6; i++) begin
            pc_value += 32'd4;
            tick();
            chk("runoff_still_run", 32'(state_o), 32'(ST_RUN));
        end
        pc_value += 32'd4;
        tick();
        chk("runoff_idle", 32'(state_o), 32'(ST_IDLE));
        chk("runoff_start", 32'(cpu_start), 0);
        chk("runoff_count", cycle_count, 32'd27);

        // Bouncing run switch must never boot
        for (int i = 0; i < 20; i++) begin
            sw_run = ((i / 2) % 2) == 0;
            tick();
            chk("bounce_state", 32'(state_o), 32'(ST_IDLE));
            chk("bounce_start", 32'(cpu_start), 0);
        end
        sw_run = 1'b0;
        repeat (8) tick();
        chk("bounce_settled", 32'(state_o), 32'(ST_IDLE));

        // Single-step mode: three presses give three one-cycle enables
        sw_step_mode = 1'b1;
        sw_run = 1'b1;
        repeat (11) tick();
        chk("step_state", 32'(state_o), 32'(ST_STEP_WAIT));
        chk("step_count_clr", cycle_count, 0);
        chk("step_ce_idle", 32'(cpu_ce), 0);
        ce_cycles = 0; ce_rises = 0; prev_ce = 1'b0;
        for (int p = 0; p < 6; p++) begin
            btn_step = (p % 2) == 0;
            for (int c = 0; c < 10; c++) begin
                pc_value += 32'd4;
                tick();
                if (cpu_ce) ce_cycles++;
                if (cpu_ce && !prev_ce) ce_rises++;
                prev_ce = cpu_ce;
            end
        end
        chk("step_ce_cycles", 32'(ce_cycles), 32'd3);
        chk("step_ce_pulses", 32'(ce_rises), 32'd3);
        chk("step_count", cycle_count, 32'd3);
        chk("step_sat_count", 32'(sat_count), 32'd3);

        // Halt on repeated PC
        sw_step_mode = 1'b0;
        wait_state(ST_RUN, "step_to_run");
        pc_value = 32'h0; tick();
        pc_value = 32'h4; tick();
        pc_value = 32'h8; tick();
        chk("halt_pre_state", 32'(state_o), 32'(ST_RUN));
        chk("halt_pre_flag", 32'(halted), 0);
        pc_value = 32'h8; tick();
        chk("halt_state", 32'(state_o), 32'(ST_HALTED));
        chk("halt_flag", 32'(halted), 1);
        chk("halt_ce", 32'(cpu_ce), 0);
        chk("halt_start", 32'(cpu_start), 1);
        chk("halt_count", cycle_count, 32'd7);
        for (int i = 0; i < 5; i++) begin
            pc_value = $urandom;
            tick();
            chk("halt_frozen_count", cycle_count, 32'd7);
            chk("halt_frozen_ce", 32'(cpu_ce), 0);
        end

        // Leaving HALTED through run=0
        sw_run = 1'b0;
        repeat (6) tick();
        chk("halt_abort_wait", 32'(state_o), 32'(ST_HALTED));
        tick();
        chk("halt_abort_idle", 32'(state_o), 32'(ST_IDLE));
        chk("halt_abort_start", 32'(cpu_start), 0);
        chk("halt_abort_sticky", 32'(halted), 1);

        // Run pulse just long enough to boot, dropping before the hold ends
        sw_run = 1'b1;
        repeat (4) tick();
        sw_run = 1'b0;
        repeat (3) tick();
        chk("bootabort_boot", 32'(state_o), 32'(ST_BOOT));
        chk("bootabort_halted_clr", 32'(halted), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bootabort_hold", 32'(state_o), 32'(ST_BOOT));
        end
        tick();
        chk("bootabort_idle", 32'(state_o), 32'(ST_IDLE));
        chk("bootabort_start", 32'(cpu_start), 0);
        chk("bootabort_ce", 32'(cpu_ce), 0);

        // Random PC streams against a sequence-level halt model
        for (int r = 0; r < 3; r++) begin
            sw_run = 1'b1;
            wait_state(ST_RUN, "rand_boot");
            chk("rand_start_count", cycle_count, 0);
            q.delete();
            cnt_m = 0;
            hit = 1'b0;
            for (int i = 0; i < 30; i++) begin
                chk("rand_state", 32'(state_o), hit ? 32'(ST_HALTED) : 32'(ST_RUN));
                chk("rand_halted", 32'(halted), 32'(hit));
                chk("rand_count", cycle_count, 32'(cnt_m));
                chk("rand_sat", 32'(sat_count), sat15(cnt_m));
                pc_value = 32'($urandom_range(7, 0)) << 2;
                if (!hit) begin
                    q.push_back(pc_value);
                    cnt_m++;
                    if (q.size() > 1 && q[q.size()-1] == q[q.size()-2]) hit = 1'b1;
                end
                tick();
            end
            sw_run = 1'b0;
            wait_state(ST_IDLE, "rand_idle");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
